mem_wb_stage: RTL

- MEM/WB pipeline register plus write-back data selection for the 5-stage MIPS pipeline.
- Sits directly downstream of the MEM stage and consumes its data-memory read output and the EX/MEM control/data fields.
- Registers the selected write-back value, destination and write enable for the register file.
- Exposes a WB forwarding source and a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 93 +++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select, forwarding and retire count.
// Optional byte/halfword load extraction when SUBWORD_LOAD_EN is defined.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             EX_Valid,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_RegDest,
  input  logic             EX_MemtoReg,
  input  logic [31:0]      EX_ALUOut,
  input  logic [2:0]       EX_LoadType,
  input  logic [31:0]      MEM_ReadData,
  output logic             WB_Valid,
  output logic             WB_RegWrite,
  output logic [4:0]       WB_RegDest,
  output logic [31:0]      WB_WrData,
  output logic [31:0]      WBForwardSrc,
  output logic             WBForwardValid,
  output logic [CNT_W-1:0] RetireCount
);

  logic [31:0]      load_data;
  logic [31:0]      sel;
  logic             wen;
  logic [CNT_W-1:0] retire_cnt;

`ifdef SUBWORD_LOAD_EN
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = MEM_ReadData[7:0];
    case (EX_ALUOut[1:0])
      2'd1:    byte_v = MEM_ReadData[15:8];
      2'd2:    byte_v = MEM_ReadData[23:16];
      2'd3:    byte_v = MEM_ReadData[31:24];
      default: byte_v = MEM_ReadData[7:0];
    endcase
    half_v = EX_ALUOut[1] ? MEM_ReadData[31:16]
                          : MEM_ReadData[15:0];
  end

  always_comb begin
    load_data = MEM_ReadData;
    case (EX_LoadType)
      3'b001:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b010:  load_data = {24'd0, byte_v};
      3'b011:  load_data = {{16{half_v[15]}}, half_v};
      3'b100:  load_data = {16'd0, half_v};
      default: load_data = MEM_ReadData;
    endcase
  end
`else
  // Word-only loads: load type has no effect in this build.
  logic unused_load_type;
  assign unused_load_type = ^EX_LoadType;
  assign load_data = MEM_ReadData;
`endif

  assign sel = EX_MemtoReg ? load_data : EX_ALUOut;
  assign wen = EX_Valid & EX_RegWrite & (EX_RegDest != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WB_Valid    <= 1'b0;
      WB_RegWrite <= 1'b0;
      WB_RegDest  <= 5'd0;
      WB_WrData   <= 32'd0;
      retire_cnt  <= '0;
    end else if (Flush) begin
      WB_Valid    <= 1'b0;
      WB_RegWrite <= 1'b0;
      WB_RegDest  <= 5'd0;
      WB_WrData   <= 32'd0;
    end else if (!Stall) begin
      WB_Valid    <= EX_Valid;
      WB_RegWrite <= wen;
      WB_RegDest  <= EX_RegDest;
      WB_WrData   <= sel;
      if (EX_Valid)
        retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign WBForwardSrc   = WB_WrData;
  assign WBForwardValid = WB_Valid & WB_RegWrite;
  assign RetireCount    = retire_cnt;

endmodule
